// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared types and constants for the I/D cache memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    // Arbiter FSM encoding; IDLE is the only non-busy state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        DRD  = 2'd2,
        IRD  = 2'd3
    } arb_state_t;

    localparam int PC_BITS_DEF   = 20;
    localparam int LINE_BITS_DEF = 128;

    // Line index width: one line holds 16 bytes, so the low 4 PC bits drop out.
    function automatic int line_addr_bits(input int pc_bits);
        return pc_bits - 4;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported line-wide backing memory between I-fill, D-fill and D write-back.
// Latency: 1 cycle of arbitration (one IDLE cycle) per transaction, plus backing memory latency.
// Backpressure: requesters hold req/addr/data until their done pulse; one transaction outstanding.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   Ic_mem_req/Ic_mem_addr       I-cache line read request; F_mem_inst/F_mem_valid return it
//   Dc_mem_req/Dc_mem_addr       D-cache line read request; MEM_data_line/MEM_mem_valid return it
//   Dc_wb_we/Dc_wb_addr/_wline   D-cache dirty write-back; Dc_wb_done acknowledges it
//   mem_req/we/addr/wline        backing memory request, held until mem_valid
//   mem_rline/mem_valid          backing memory read data and one-cycle completion pulse
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int PC_BITS    = PC_BITS_DEF,
    parameter int LINE_BITS  = LINE_BITS_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Ic_mem_req,
    input  logic [PC_BITS-5:0]   Ic_mem_addr,
    output logic [LINE_BITS-1:0] F_mem_inst,
    output logic                 F_mem_valid,
    input  logic                 Dc_mem_req,
    input  logic [PC_BITS-5:0]   Dc_mem_addr,
    output logic [LINE_BITS-1:0] MEM_data_line,
    output logic                 MEM_mem_valid,
    input  logic                 Dc_wb_we,
    input  logic [PC_BITS-5:0]   Dc_wb_addr,
    input  logic [LINE_BITS-1:0] Dc_wb_wline,
    output logic                 Dc_wb_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [PC_BITS-5:0]   mem_addr,
    output logic [LINE_BITS-1:0] mem_wline,
    input  logic [LINE_BITS-1:0] mem_rline,
    input  logic                 mem_valid
);

    localparam int         AW         = line_addr_bits(PC_BITS);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t      state, state_nxt;
    logic [3:0]      starve_cnt, starve_nxt, starve_inc;
    logic [AW-1:0]   sel_addr;
    logic            launch;

    assign starve_inc = (starve_cnt >= STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;

    // Next state and starve counter. The starve check comes first so the
    // I-side wins once the D-side has taken STARVE_MAX grants in a row.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (Ic_mem_req && (starve_cnt == STARVE_LIM)) begin
                    state_nxt  = IRD;
                    starve_nxt = 4'd0;
                end else if (Dc_wb_we) begin
                    state_nxt  = WB;
                    starve_nxt = Ic_mem_req ? starve_inc : 4'd0;
                end else if (Dc_mem_req) begin
                    state_nxt  = DRD;
                    starve_nxt = Ic_mem_req ? starve_inc : 4'd0;
                end else if (Ic_mem_req) begin
                    state_nxt  = IRD;
                    starve_nxt = 4'd0;
                end else begin
                    starve_nxt = 4'd0;
                end
            end
            default: begin
                if (mem_valid) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Address of whichever requester is being granted this cycle.
    always_comb begin
        sel_addr = '0;
        case (state_nxt)
            WB:      sel_addr = Dc_wb_addr;
            DRD:     sel_addr = Dc_mem_addr;
            IRD:     sel_addr = Ic_mem_addr;
            default: sel_addr = '0;
        endcase
    end

    assign launch = (state == IDLE) && (state_nxt != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wline  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (launch) begin
                mem_req  <= 1'b1;
                mem_we   <= (state_nxt == WB);
                mem_addr <= sel_addr;
                if (state_nxt == WB) begin
                    mem_wline <= Dc_wb_wline;
                end
            end else if ((state != IDLE) && mem_valid) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
        end
    end

    // Read data goes to both caches; only the qualified valid marks the owner.
    // A mem_valid seen in IDLE is masked off by the state qualification.
    assign F_mem_inst    = mem_rline;
    assign MEM_data_line = mem_rline;
    assign F_mem_valid   = mem_valid && (state == IRD);
    assign MEM_mem_valid = mem_valid && (state == DRD);
    assign Dc_wb_done    = mem_valid && (state == WB);

endmodule
